controle_fechadura: RTL
=======================

# controle_fechadura

Top-level access controller for the electronic lock. It holds the active configuration (beep enable, beep time, auto-relock time, master and four user passwords), checks each submitted keypad entry against the stored passwords, and drives the bolt and the door-open beeper. It enforces a lockout after repeated failures. On a master-password match it hands control to the `setup` block through `setup_on` and commits the new configuration when `data_setup_ok` pulses.

## Interface
- `CLK_FREQ`, default 1000: clk cycles per second; sets the internal 1 s prescaler.
- `NUM_TENT`, default 3: consecutive failed entries that trigger a lockout.
- `T_BLOQ`, default 30: lockout duration in seconds.
- `clk` in 1: system clock.
- `rst` in 1: reset; asynchronous, active-high.
- `digitos_value` in senhaPac_t (80): entered digits; digit 0 is the last key pressed; unused digits are 4'hF.
- `digitos_valid` in 1: one-cycle strobe; `digitos_value` is valid in this cycle.
- `sensor_porta` in 1: 1 = door closed, 0 = door open. Synchronous to clk.
- `botao_interno` in 1: one-cycle pulse from the inside open button.
- `data_setup_new` in setupPac_t: new configuration from `setup`.
- `data_setup_ok` in 1: one-cycle commit strobe from `setup`.
- `setup_on` out 1: high for the whole SETUP state.
- `tranca` out 1: 1 = bolt locked.
- `bip` out 1: beeper drive.
- `bloqueado` out 1: high during lockout.

## Operation
- **Config register `cfg`**, reset defaults:
  - `bip_status` = 1
  - `bip_time` = 5
  - `tranca_aut_time` = 5
  - `senha_master` = digits[3:0] = 1,2,3,4 (digit 0 = 4), other digits F
  - `senha_1..4` = all F
- **Slot usability:** a password slot is usable only if it is not all F.
- **Match rule:** exact 80-bit equality with a usable slot. An all-F entry is ignored: no state change, no attempt counted.
- **States:** TRANCADO (reset), VERIFICA, DESTRANCADO, PORTA_ABERTA, BLOQUEIO, SETUP.
- **TRANCADO:**
  - `botao_interno` → DESTRANCADO and clears `tent`.
  - Otherwise `digitos_valid` with a non-all-F entry latches the entry → VERIFICA.
- **VERIFICA**, decided in one cycle:
  - Master match with `sensor_porta`=1 → SETUP, `tent`=0.
  - User match, or master match with the door open → DESTRANCADO, `tent`=0.
  - No match → `tent`+1. If the new `tent` equals `NUM_TENT` → BLOQUEIO, else → TRANCADO.
- **DESTRANCADO** (bolt open, door closed):
  - `sensor_porta`=0 → PORTA_ABERTA.
  - Elapsed seconds reaching `tranca_aut_time` → TRANCADO.
- **PORTA_ABERTA:**
  - `sensor_porta`=1 → DESTRANCADO; the timer restarts.
  - `bip`=1 while `bip_status`=1 and elapsed ≥ `bip_time`.
- **BLOQUEIO:**
  - `digitos_valid` is ignored.
  - `botao_interno` → DESTRANCADO.
  - After `T_BLOQ` s → TRANCADO.
  - Either exit clears `tent`.
- **SETUP:**
  - `digitos_valid` and `botao_interno` are ignored.
  - `data_setup_ok` → `cfg` <= `data_setup_new` → TRANCADO.
- **Strobes outside their states:** `data_setup_ok` outside SETUP is ignored. `digitos_valid` outside TRANCADO is ignored.
- **Door opened while TRANCADO** (forced): no state change, no beep.

## Timing
- **Outputs:** all outputs are registered Moore decodes of state, with one exception: `bip` also depends on the registered timer.
  - `tranca` = 0 in DESTRANCADO and PORTA_ABERTA, else 1.
  - `setup_on` = 1 in SETUP only.
  - `bloqueado` = 1 in BLOQUEIO only.
- **Reset:** `tranca`=1, `setup_on`=0, `bip`=0, `bloqueado`=0, `tent`=0, `cfg`=defaults, prescaler=0, seconds=0.
- **Reset mid-SETUP or mid-unlock:** returns to TRANCADO immediately and discards uncommitted data.
- **Entry latency:** `digitos_valid` sampled at edge N → VERIFICA after N. The new state and outputs are valid after edge N+1 (`tranca` falls after N+1 on a match).
- **Timer:**
  - Prescaler counts 0..`CLK_FREQ`-1; the seconds counter is 6 bits and saturates at 63.
  - Both are cleared on every state change, including PORTA_ABERTA→DESTRANCADO.
  - Elapsed = k exactly k·`CLK_FREQ` cycles after state entry.
  - Auto-relock: TRANCADO is entered on the edge where elapsed becomes `tranca_aut_time`.
- **Commit:** `data_setup_ok` at edge M → `cfg` updated and `setup_on`=0 after M. The new `cfg` is used from the next entry.
- **Simultaneous events in TRANCADO:** if `botao_interno` and `digitos_valid` arrive in the same cycle, the button wins and the digits are dropped.
- **Simultaneous events in DESTRANCADO:** if the door opens on the same edge the relock timeout is reached, the door wins → PORTA_ABERTA.

## Test plan
- **Default master entry:** after reset, enter digits[3:0]=1,2,3,4 (rest F) with door closed → `setup_on`=1 two edges later. Pulse `data_setup_ok` with `senha_1`=…5,6,7,8 → `setup_on`=0. Entering 5678 → `tranca`=0.
- **Auto-relock:** `CLK_FREQ`=10, user match with door kept closed → `tranca`=0, then `tranca`=1 exactly 50 cycles after it fell.
- **Beep timing:** after unlock, open the door → `tranca` stays 0, `bip` rises 50 cycles after door open. Close the door → `bip`=0 and the relock countdown restarts from 0.
- **Lockout:** 3 wrong entries → `bloqueado`=1. A correct entry during lockout is ignored. After 300 cycles → `bloqueado`=0 and `tent`=0. `botao_interno` during lockout → `tranca`=0.
- **Ignored and colliding inputs:** an all-F entry causes no state change and no count. `botao_interno` in the same cycle as a wrong entry → unlock with `tent` unchanged at 0.
- **Reset mid-SETUP:** assert `rst` while in SETUP → `setup_on`=0 immediately and the master password is back to 1234.

Source files
------------

// File: rtl/controle_fechadura_if.sv
// Keypad/door/setup signal bundle between the lock controller and its environment.
// data_setup_new is a flat 413-bit word (MSB first):
//   [412] bip_status, [411:406] bip_time, [405:400] tranca_aut_time,
//   [399:320] senha_master, [319:240] senha_1, [239:160] senha_2,
//   [159:80] senha_3, [79:0] senha_4.
// Each password is 20 BCD digits, digit 0 (last key pressed) in bits [3:0],
// unused digits 4'hF.
interface controle_fechadura_if;
  logic [79:0]  digitos_value;
  logic         digitos_valid;
  logic         sensor_porta;
  logic         botao_interno;
  logic [412:0] data_setup_new;
  logic         data_setup_ok;
  logic         setup_on;
  logic         tranca;
  logic         bip;
  logic         bloqueado;

  modport master (
    output digitos_value, digitos_valid, sensor_porta, botao_interno,
           data_setup_new, data_setup_ok,
    input  setup_on, tranca, bip, bloqueado
  );

  modport slave (
    input  digitos_value, digitos_valid, sensor_porta, botao_interno,
           data_setup_new, data_setup_ok,
    output setup_on, tranca, bip, bloqueado
  );
endinterface

// File: rtl/controle_fechadura.sv
// Electronic lock access controller: password check, bolt/beeper control,
// lockout after repeated failures and hand-off to the setup block.
module controle_fechadura #(
  parameter int CLK_FREQ = 1000,
  parameter int NUM_TENT = 3,
  parameter int T_BLOQ   = 30
) (
  input  logic clk,
  input  logic rst,
  controle_fechadura_if.slave bus
);

  localparam logic [2:0] TRANCADO     = 3'd0;
  localparam logic [2:0] VERIFICA     = 3'd1;
  localparam logic [2:0] DESTRANCADO  = 3'd2;
  localparam logic [2:0] PORTA_ABERTA = 3'd3;
  localparam logic [2:0] BLOQUEIO     = 3'd4;
  localparam logic [2:0] SETUP        = 3'd5;

  localparam logic [79:0] ALL_F      = '1;
  localparam logic [79:0] MASTER_DEF = 80'hFFFF_FFFF_FFFF_FFFF_1234;
  localparam int          PW         = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);

  logic [2:0]       r_state;
  logic [79:0]      r_entrada;
  logic [7:0]       r_tent;
  logic [PW-1:0]    r_presc;
  logic [5:0]       r_seg;
  logic             r_cfg_bip_status;
  logic [5:0]       r_cfg_bip_time;
  logic [5:0]       r_cfg_aut_time;
  logic [79:0]      r_cfg_master;
  logic [3:0][79:0] r_cfg_user;
  logic             r_tranca;
  logic             r_setup_on;
  logic             r_bip;
  logic             r_bloqueado;

  logic [2:0]       w_next;
  logic [7:0]       w_tent_next;
  logic             w_latch;
  logic             w_commit;
  logic             w_tick;
  logic [5:0]       w_seg_inc;
  logic [5:0]       w_seg_next;
  logic [PW-1:0]    w_presc_next;
  logic             w_master_match;
  logic             w_user_match;
  logic             w_tent_full;

  // The seconds counter advances on the last prescaler cycle and saturates at 63.
  assign w_tick      = (r_presc == PRESC_MAX);
  assign w_seg_inc   = (r_seg == 6'd63) ? r_seg : r_seg + 6'd1;
  assign w_tent_full = ((r_tent + 8'd1) == 8'(NUM_TENT));

  // A slot only matches when it holds a real password (not all F).
  assign w_master_match = (r_cfg_master != ALL_F) && (r_entrada == r_cfg_master);

  // Compare the latched entry against every usable user slot.
  always_comb begin
    w_user_match = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((r_cfg_user[i] != ALL_F) && (r_entrada == r_cfg_user[i])) begin
        w_user_match = 1'b1;
      end
    end
  end

  // Next-state, attempt counter, entry latch and commit decisions.
  always_comb begin
    w_next      = r_state;
    w_tent_next = r_tent;
    w_latch     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      TRANCADO: begin
        if (bus.botao_interno) begin
          w_next      = DESTRANCADO;
          w_tent_next = 8'd0;
        end else if (bus.digitos_valid && (bus.digitos_value != ALL_F)) begin
          w_latch = 1'b1;
          w_next  = VERIFICA;
        end
      end
      VERIFICA: begin
        if (w_master_match && bus.sensor_porta) begin
          w_next      = SETUP;
          w_tent_next = 8'd0;
        end else if (w_user_match || w_master_match) begin
          w_next      = DESTRANCADO;
          w_tent_next = 8'd0;
        end else begin
          w_tent_next = r_tent + 8'd1;
          w_next      = w_tent_full ? BLOQUEIO : TRANCADO;
        end
      end
      DESTRANCADO: begin
        if (!bus.sensor_porta) begin
          w_next = PORTA_ABERTA;
        end else if (w_tick && (w_seg_inc == r_cfg_aut_time)) begin
          w_next = TRANCADO;
        end
      end
      PORTA_ABERTA: begin
        if (bus.sensor_porta) begin
          w_next = DESTRANCADO;
        end
      end
      BLOQUEIO: begin
        if (bus.botao_interno) begin
          w_next      = DESTRANCADO;
          w_tent_next = 8'd0;
        end else if (w_tick && (w_seg_inc == 6'(T_BLOQ))) begin
          w_next      = TRANCADO;
          w_tent_next = 8'd0;
        end
      end
      SETUP: begin
        if (bus.data_setup_ok) begin
          w_commit = 1'b1;
          w_next   = TRANCADO;
        end
      end
      default: begin
        w_next = TRANCADO;
      end
    endcase
  end

  // Elapsed-time counters restart from zero on every state change.
  always_comb begin
    w_presc_next = r_presc + PW'(1);
    w_seg_next   = r_seg;
    if (w_next != r_state) begin
      w_presc_next = '0;
      w_seg_next   = 6'd0;
    end else if (w_tick) begin
      w_presc_next = '0;
      w_seg_next   = w_seg_inc;
    end
  end

  // State, counters and Moore outputs registered together from the next-state view.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= TRANCADO;
      r_tent      <= 8'd0;
      r_presc     <= '0;
      r_seg       <= 6'd0;
      r_entrada   <= ALL_F;
      r_tranca    <= 1'b1;
      r_setup_on  <= 1'b0;
      r_bip       <= 1'b0;
      r_bloqueado <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_tent      <= w_tent_next;
      r_presc     <= w_presc_next;
      r_seg       <= w_seg_next;
      if (w_latch) begin
        r_entrada <= bus.digitos_value;
      end
      r_tranca    <= !((w_next == DESTRANCADO) || (w_next == PORTA_ABERTA));
      r_setup_on  <= (w_next == SETUP);
      r_bloqueado <= (w_next == BLOQUEIO);
      r_bip       <= (w_next == PORTA_ABERTA) && r_cfg_bip_status &&
                     (w_seg_next >= r_cfg_bip_time);
    end
  end

  // Active configuration: factory defaults on reset, replaced only on a setup commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg_bip_status <= 1'b1;
      r_cfg_bip_time   <= 6'd5;
      r_cfg_aut_time   <= 6'd5;
      r_cfg_master     <= MASTER_DEF;
      r_cfg_user       <= {4{ALL_F}};
    end else if (w_commit) begin
      r_cfg_bip_status <= bus.data_setup_new[412];
      r_cfg_bip_time   <= bus.data_setup_new[411:406];
      r_cfg_aut_time   <= bus.data_setup_new[405:400];
      r_cfg_master     <= bus.data_setup_new[399:320];
      r_cfg_user[0]    <= bus.data_setup_new[319:240];
      r_cfg_user[1]    <= bus.data_setup_new[239:160];
      r_cfg_user[2]    <= bus.data_setup_new[159:80];
      r_cfg_user[3]    <= bus.data_setup_new[79:0];
    end
  end

  assign bus.tranca    = r_tranca;
  assign bus.setup_on  = r_setup_on;
  assign bus.bip       = r_bip;
  assign bus.bloqueado = r_bloqueado;

endmodule
